// File: rtl/uart_pkg.sv
// Shared UART FIFO constants, used by both the TX and RX FIFOs.
package uart_pkg;

    // Default number of byte entries in a UART FIFO (16550-compatible).
    localparam int UART_FIFO_DEPTH = 16;

    // Width of a level counter able to hold 0..UART_FIFO_DEPTH.
    localparam int UART_FIFO_CW = $clog2(UART_FIFO_DEPTH) + 1;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART FIFOs: DEPTH x 8 register array with a
// synchronous write port and an asynchronous read port. Contents are not
// reset; the owning FIFO's count decides which entries are meaningful.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Write port: one byte per cycle when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers THR writes, presents the head byte to the
// transmitter and retires it on each rising edge of the transmitter's pop.
// Build option UART_FIFO_MODE_EN: when defined, a full DEPTH-entry FIFO with
// a programmable trigger level; when undefined, a 16450-style single-byte
// holding register (full = !empty, thre_irq = empty, thresh unused).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    input  logic [CW-1:0] thresh,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overrun,
    output logic          thre_irq
);

    localparam int PW = CW - 1;

`ifdef UART_FIFO_MODE_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    localparam logic [CW-1:0] CAP_C = CW'(CAP);

    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_overrun;
    logic          r_pop_q;
    logic          w_empty;
    logic          w_full;
    logic          w_pop_evt;
    logic          w_flush;
    logic          w_retire;
    logic          w_write;
    logic          w_drop;
    logic [7:0]    w_rdata;

    // Pointer advance; in holding-register mode only entry 0 is ever used.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (CAP == 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CAP_C);
    // A held pop retires only once: act on its rising edge.
    assign w_pop_evt = pop & ~r_pop_q;
    // Disabling the FIFO behaves like a continuous flush.
    assign w_flush   = clr | ~en;
    assign w_retire  = w_pop_evt & ~w_empty & ~w_flush;
    // A full FIFO still accepts a byte when the head retires in the same cycle.
    assign w_write   = push & ~w_flush & (~w_full | w_pop_evt);
    assign w_drop    = push & ~w_flush & w_full & ~w_pop_evt;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_write),
        .i_waddr (r_wp),
        .i_wdata (wdata),
        .i_raddr (r_rp),
        .o_rdata (w_rdata)
    );

    // Level update: simultaneous write and retire leave the level unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_write && !w_retire) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_write && w_retire) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Pointers, level and sticky overrun; reset and flush empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_write) begin
                r_wp <= ptr_inc(r_wp);
            end
            if (w_retire) begin
                r_rp <= ptr_inc(r_rp);
            end
            r_count <= w_count_next;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Pop history for edge detection; deliberately not cleared by a flush so
    // a pop held across clr cannot retire a freshly written byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop_q <= 1'b0;
        end else begin
            r_pop_q <= pop;
        end
    end

    assign dout    = w_empty ? 8'h00 : w_rdata;
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_overrun;

`ifdef UART_FIFO_MODE_EN
    assign thre_irq = (r_count <= thresh);
`else
    // Holding-register mode ignores the trigger level; the second term is
    // always zero when it matters and only keeps thresh connected.
    assign thre_irq = w_empty | (w_empty & (^thresh));
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A queue-based model of the FIFO is
// compared against the DUT every cycle; directed sequences add literal
// expectations. Works in both UART_FIFO_MODE_EN builds.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_FIFO_MODE_EN
    localparam int CAP = DEPTH;
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam int CAP = 1;
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr;
    logic          push;
    logic [7:0]    wdata;
    logic          pop;
    logic [CW-1:0] thresh;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          thre_irq;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [7:0] q[$];
    bit         m_ovr = 1'b0;
    bit         m_pop_q = 1'b0;
    bit         m_pe;
    bit         m_take;
    bit         m_room;
    int         n;

    uart_tx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .push     (push),
        .wdata    (wdata),
        .pop      (pop),
        .thresh   (thresh),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .thre_irq (thre_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bounded queue with edge-triggered retire.
    always @(posedge clk) begin
        m_pe = pop && !m_pop_q;
        if (rst) begin
            q.delete();
            m_ovr = 1'b0;
            m_pop_q = 1'b0;
        end else begin
            if (clr || !en) begin
                q.delete();
                m_ovr = 1'b0;
            end else begin
                m_take = m_pe && (q.size() > 0);
                m_room = (q.size() < CAP) || m_pe;
                if (m_take) begin
                    $display("retire %h", q[0]);
                    void'(q.pop_front());
                end
                if (push && m_room) begin
                    q.push_back(wdata);
                    $display("push   %h level %0d", wdata, q.size());
                end else if (push) begin
                    m_ovr = 1'b1;
                    $display("drop   %h (full)", wdata);
                end
            end
            m_pop_q = pop;
        end
    end

    // Compare every cycle, 2 time units after the active edge.
    always begin
        @(posedge clk);
        #2;
        if (chk_en) begin
            n = q.size();
            chk("count",   32'(count),    32'(n));
            chk("empty",   32'(empty),    32'(n == 0));
            chk("full",    32'(full),     32'(n == CAP));
            chk("dout",    32'(dout),     (n > 0) ? 32'(q[0]) : 32'h0);
            chk("overrun", 32'(overrun),  32'(m_ovr));
            chk("thre_irq", 32'(thre_irq),
                FIFO_MODE ? 32'(n <= int'(thresh)) : 32'(n == 0));
        end
    end

    // Advance one cycle; returns 3 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic do_push(input logic [7:0] b);
        push  = 1'b1;
        wdata = b;
        cyc();
        push  = 1'b0;
    endtask

    task automatic pop_pulse();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        cyc();
    endtask

    task automatic flush();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; push = 1'b0;
        wdata = 8'h00; pop = 1'b0; thresh = '0;
        repeat (3) cyc();
        rst = 1'b0;
        en  = 1'b1;
        chk_en = 1'b1;
        cyc();
        // Reset then idle
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout",  32'(dout),  32'h00);
        chk("rst_thre",  32'(thre_irq), 32'd1);

        // Push while disabled is dropped without overrun
        en = 1'b0;
        do_push(8'h55);
        en = 1'b1;
        cyc();
        chk("dis_count", 32'(count), 32'd0);
        chk("dis_ovr",   32'(overrun), 32'd0);

        // Held pop: retires once, never again across a flush
        do_push(8'hAA);
        pop = 1'b1;
        cyc();
        do_push(8'hBB);
        flush();
        do_push(8'hCC);
        cyc();
        chk("held_count", 32'(count), 32'd1);
        chk("held_dout",  32'(dout),  32'hCC);
        pop = 1'b0;
        cyc();
        flush();

`ifdef UART_FIFO_MODE_EN
        // Held pop retires only the head
        do_push(8'hA5);
        do_push(8'h3C);
        chk("two_count", 32'(count), 32'd2);
        chk("two_dout",  32'(dout),  32'hA5);
        pop = 1'b1;
        repeat (20) cyc();
        chk("hold_dout",  32'(dout),  32'h3C);
        chk("hold_count", 32'(count), 32'd1);
        pop = 1'b0;
        cyc();
        flush();

        // Overfill by one
        for (int i = 0; i < 16; i++) do_push(8'h40 + 8'(i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd16);
        do_push(8'hEE);
        chk("ovr_set",   32'(overrun), 32'd1);
        chk("ovr_count", 32'(count),   32'd16);
        chk("ovr_dout",  32'(dout),    32'h40);
        flush();
        chk("clr_count", 32'(count),   32'd0);
        chk("clr_ovr",   32'(overrun), 32'd0);

        // Full with push and pop edge in the same cycle
        for (int i = 0; i < 16; i++) do_push(8'h60 + 8'(i));
        pop = 1'b1;
        do_push(8'h77);
        chk("pp_count", 32'(count),   32'd16);
        chk("pp_ovr",   32'(overrun), 32'd0);
        chk("pp_dout",  32'(dout),    32'h61);
        cyc();
        chk("pp_hold",  32'(count),   32'd16);
        pop = 1'b0;
        cyc();
        flush();

        // Fill, drain through wrap, refill; trigger level
        for (int i = 0; i < 16; i++) do_push(8'h80 + 8'(i));
        for (int i = 0; i < 16; i++) pop_pulse();
        chk("drain_empty", 32'(empty), 32'd1);
        thresh = CW'(2);
        do_push(8'hC1);
        do_push(8'hC2);
        do_push(8'hC3);
        chk("ref_dout", 32'(dout), 32'hC1);
        chk("thr3",     32'(thre_irq), 32'd0);
        pop_pulse();
        chk("thr2",     32'(thre_irq), 32'd1);
        chk("ref_dout2", 32'(dout), 32'hC2);
`else
        // Holding-register mode
        thresh = CW'(5);
        do_push(8'h11);
        chk("hr_full",  32'(full),  32'd1);
        chk("hr_count", 32'(count), 32'd1);
        chk("hr_thre",  32'(thre_irq), 32'd0);
        do_push(8'h22);
        chk("hr_ovr",   32'(overrun), 32'd1);
        chk("hr_dout",  32'(dout),    32'h11);
        pop = 1'b1;
        do_push(8'h33);
        pop = 1'b0;
        chk("hr_pp_dout", 32'(dout),  32'h33);
        chk("hr_pp_ovr",  32'(overrun), 32'd1);
        cyc();
        pop_pulse();
        chk("hr_empty", 32'(empty),    32'd1);
        chk("hr_thre1", 32'(thre_irq), 32'd1);
        flush();
        chk("hr_clr",   32'(overrun),  32'd0);
`endif
        cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
